// File: rtl/lib_pkg.sv
// Shared library package: sizing helpers used by the switch allocator and its arbiters.
package lib_pkg;

  // Width of an index into n items; never narrower than one bit so N=1 still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : lib_pkg

// File: rtl/lib_arbiter_rr.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr, wrapping N-1 -> 0.
module lib_arbiter_rr
  import lib_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [0:N-1]  req,
  input  logic [IW-1:0] ptr,
  output logic [0:N-1]  gnt,
  output logic [IW-1:0] gnt_idx
);

  always_comb begin
    int   idx;
    logic found;
    // NOTE: every output and temporary gets a default before the loop so no path leaves
    // a value unassigned; otherwise synthesis infers latches.
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = IW'(idx);
      end
    end
  end

endmodule : lib_arbiter_rr

// File: rtl/lib_switch_allocator_onehot.sv
// Wormhole switch allocator: per-output round-robin arbitration plus packet lock until the tail flit,
// producing the one-hot crossbar select matrix, input pops (o_grant) and output valids.
module lib_switch_allocator_onehot
  import lib_pkg::*;
#(
  parameter int N = 4,
  parameter int M = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [0:N-1][0:M-1]   i_req,
  input  logic [0:N-1]          i_tail,
  input  logic [0:M-1]          i_out_ready,
  output logic [0:M-1][0:N-1]   o_sel,
  output logic [0:N-1]          o_grant,
  output logic [0:M-1]          o_valid
);

  localparam int IW = idx_width(N);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  lock_state_e         state_q [M];
  lock_state_e         state_d [M];
  logic [IW-1:0]       owner_q [M];
  logic [IW-1:0]       owner_d [M];
  logic [IW-1:0]       ptr_q   [M];
  logic [IW-1:0]       ptr_d   [M];

  logic [0:M-1]        req_mask [N];
  logic [0:N-1]        busy;
  logic [0:N-1]        cand    [M];
  logic [0:N-1]        arb_gnt [M];
  logic [IW-1:0]       arb_idx [M];

  logic [0:M-1][0:N-1] sel;
  logic [0:N-1]        grant;
  logic [0:M-1]        xfer;

  function automatic logic [IW-1:0] inc_idx(input logic [IW-1:0] idx);
    return (int'(idx) == N - 1) ? '0 : idx + IW'(1);
  endfunction

  // A malformed request row keeps only its lowest-index output, so each input targets at most one output.
  always_comb begin
    logic found;
    for (int j = 0; j < N; j++) begin
      req_mask[j] = '0;
      found       = 1'b0;
      for (int m = 0; m < M; m++) begin
        if (i_req[j][m] && !found) begin
          req_mask[j][m] = 1'b1;
          found          = 1'b1;
        end
      end
    end
  end

  // Inputs already streaming a packet through some output may not start a second one elsewhere.
  always_comb begin
    busy = '0;
    for (int m = 0; m < M; m++) begin
      if (state_q[m] == ST_LOCKED) busy[owner_q[m]] = 1'b1;
    end
  end

  always_comb begin
    for (int m = 0; m < M; m++) begin
      for (int j = 0; j < N; j++) begin
        cand[m][j] = req_mask[j][m] & ~busy[j];
      end
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_arb
    lib_arbiter_rr #(
      .N  (N),
      .IW (IW)
    ) u_arb (
      .req     (cand[m]),
      .ptr     (ptr_q[m]),
      .gnt     (arb_gnt[m]),
      .gnt_idx (arb_idx[m])
    );
  end

  always_comb begin
    sel     = '0;
    grant   = '0;
    xfer    = '0;
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    for (int m = 0; m < M; m++) begin
      if (state_q[m] == ST_IDLE) begin
        // The winner is shown on o_sel even when the output is stalled; it is re-arbitrated next cycle.
        if (|cand[m]) begin
          sel[m] = arb_gnt[m];
          if (i_out_ready[m]) begin
            xfer[m]           = 1'b1;
            grant[arb_idx[m]] = 1'b1;
            if (i_tail[arb_idx[m]]) begin
              ptr_d[m] = inc_idx(arb_idx[m]);
            end else begin
              state_d[m] = ST_LOCKED;
              owner_d[m] = arb_idx[m];
            end
          end
        end
      end else begin
        // Locked: hold the crossbar path; an owner with no request is a bubble, not a release.
        sel[m][owner_q[m]] = 1'b1;
        if (req_mask[owner_q[m]][m] && i_out_ready[m]) begin
          xfer[m]           = 1'b1;
          grant[owner_q[m]] = 1'b1;
          if (i_tail[owner_q[m]]) begin
            state_d[m] = ST_IDLE;
            ptr_d[m]   = inc_idx(owner_q[m]);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int m = 0; m < M; m++) begin
        state_q[m] <= ST_IDLE;
        owner_q[m] <= '0;
        ptr_q[m]   <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every per-output register samples the same pre-edge state.
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  assign o_sel   = reset_n ? sel   : '0;
  assign o_grant = reset_n ? grant : '0;
  assign o_valid = reset_n ? xfer  : '0;

endmodule : lib_switch_allocator_onehot

// File: tb/tb_lib_switch_allocator_onehot.sv
// Directed-vector bench for lib_switch_allocator_onehot (N=4, M=4) with hand-computed expectations.
module tb_lib_switch_allocator_onehot;

  localparam int N = 4;
  localparam int M = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [0:N-1][0:M-1] i_req;
  logic [0:N-1]        i_tail;
  logic [0:M-1]        i_out_ready;
  logic [0:M-1][0:N-1] o_sel;
  logic [0:N-1]        o_grant;
  logic [0:M-1]        o_valid;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lib_switch_allocator_onehot #(.N(N), .M(M)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_req       (i_req),
    .i_tail      (i_tail),
    .i_out_ready (i_out_ready),
    .o_sel       (o_sel),
    .o_grant     (o_grant),
    .o_valid     (o_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_invariants();
    logic hit;
    for (int m = 0; m < M; m++) check("sel_onehot0", 32'($onehot0(o_sel[m])), 32'd1);
    for (int j = 0; j < N; j++) begin
      if (o_grant[j]) begin
        hit = 1'b0;
        for (int m = 0; m < M; m++) if (o_sel[m][j] && o_valid[m]) hit = 1'b1;
        check("grant_has_valid", 32'(hit), 32'd1);
      end
    end
  endtask

  // Apply one cycle of inputs at the falling edge and settle before sampling.
  task automatic drive(input logic [0:N-1][0:M-1] req, input logic [0:N-1] tail,
                       input logic [0:M-1] rdy);
    @(negedge clk);
    i_req       = req;
    i_tail      = tail;
    i_out_ready = rdy;
    #2;
    check_invariants();
  endtask

  initial begin
    reset_n     = 1'b0;
    i_req       = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
    i_tail      = 4'b1111;
    i_out_ready = 4'b1111;
    repeat (2) @(negedge clk);
    #2;
    check("rst_sel",   32'(o_sel),   32'd0);
    check("rst_grant", 32'(o_grant), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    i_req   = '0;
    reset_n = 1'b1;

    // Single-flit to output 1 from input 2, then ptr[1]=3 shows up as input 3 beating input 0.
    drive({4'b0000, 4'b0000, 4'b0100, 4'b0000}, 4'b0010, 4'b1111);
    check("t1_sel1",  32'(o_sel[1]), 32'b0010);
    check("t1_grant", 32'(o_grant),  32'b0010);
    check("t1_valid", 32'(o_valid),  32'b0100);
    drive({4'b0100, 4'b0000, 4'b0000, 4'b0100}, 4'b1001, 4'b1111);
    check("t1_ptr3_grant", 32'(o_grant), 32'b0001);
    drive({4'b0100, 4'b0000, 4'b0000, 4'b0100}, 4'b1001, 4'b1111);
    check("t1_wrap_grant", 32'(o_grant), 32'b1000);

    // All inputs hammer output 0 with single-flit packets: rotation 0,1,2,3,0.
    begin
      logic [0:N-1] exp_rot [5];
      exp_rot = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
      for (int c = 0; c < 5; c++) begin
        drive({4'b1000, 4'b1000, 4'b1000, 4'b1000}, 4'b1111, 4'b1111);
        check("t2_grant",   32'(o_grant), 32'(exp_rot[c]));
        check("t2_onehot",  32'($countones(o_grant)), 32'd1);
        check("t2_valid",   32'(o_valid), 32'b1000);
      end
    end

    // 3-flit packet from input 1 to output 2 holds off input 3 until after the tail.
    drive({4'b0000, 4'b0010, 4'b0000, 4'b0010}, 4'b0001, 4'b1111);
    check("t3_f1_sel2", 32'(o_sel[2]), 32'b0100);
    check("t3_f1_grant", 32'(o_grant), 32'b0100);
    drive({4'b0000, 4'b0010, 4'b0000, 4'b0010}, 4'b0001, 4'b1111);
    check("t3_f2_sel2", 32'(o_sel[2]), 32'b0100);
    check("t3_f2_grant", 32'(o_grant), 32'b0100);
    drive({4'b0000, 4'b0010, 4'b0000, 4'b0010}, 4'b0101, 4'b1111);
    check("t3_f3_sel2", 32'(o_sel[2]), 32'b0100);
    check("t3_f3_grant", 32'(o_grant), 32'b0100);
    drive({4'b0000, 4'b0000, 4'b0000, 4'b0010}, 4'b0001, 4'b1111);
    check("t3_next_sel2", 32'(o_sel[2]), 32'b0001);
    check("t3_next_grant", 32'(o_grant), 32'b0001);

    // Input 2 locks output 3, then bubbles two cycles while input 0 waits.
    drive({4'b0000, 4'b0000, 4'b0001, 4'b0000}, 4'b0000, 4'b1111);
    check("t4_head_grant", 32'(o_grant), 32'b0010);
    check("t4_head_valid", 32'(o_valid), 32'b0001);
    for (int c = 0; c < 2; c++) begin
      drive({4'b0001, 4'b0000, 4'b0000, 4'b0000}, 4'b1000, 4'b1111);
      check("t4_bubble_sel3",  32'(o_sel[3]), 32'b0010);
      check("t4_bubble_grant", 32'(o_grant),  32'b0000);
      check("t4_bubble_valid", 32'(o_valid),  32'b0000);
    end
    drive({4'b0001, 4'b0000, 4'b0001, 4'b0000}, 4'b1010, 4'b1111);
    check("t4_tail_sel3",  32'(o_sel[3]), 32'b0010);
    check("t4_tail_grant", 32'(o_grant),  32'b0010);
    check("t4_tail_valid", 32'(o_valid),  32'b0001);
    drive({4'b0001, 4'b0000, 4'b0000, 4'b0000}, 4'b1000, 4'b1111);
    check("t4_after_grant", 32'(o_grant), 32'b1000);

    // Two-bit request row is reduced to the lowest output index.
    drive({4'b0000, 4'b0110, 4'b0000, 4'b0000}, 4'b0100, 4'b1111);
    check("mask_sel1",  32'(o_sel[1]), 32'b0100);
    check("mask_sel2",  32'(o_sel[2]), 32'b0000);
    check("mask_grant", 32'(o_grant),  32'b0100);
    check("mask_valid", 32'(o_valid),  32'b0100);

    // Input 1 locked on output 0 may not be picked by idle output 1.
    drive({4'b0000, 4'b1000, 4'b0000, 4'b0000}, 4'b0000, 4'b1111);
    check("excl_head_grant", 32'(o_grant), 32'b0100);
    drive({4'b0000, 4'b0100, 4'b0000, 4'b0000}, 4'b0100, 4'b1111);
    check("excl_sel0",  32'(o_sel[0]), 32'b0100);
    check("excl_sel1",  32'(o_sel[1]), 32'b0000);
    check("excl_grant", 32'(o_grant),  32'b0000);
    check("excl_valid", 32'(o_valid),  32'b0000);
    drive({4'b0000, 4'b1000, 4'b0000, 4'b0000}, 4'b0100, 4'b1111);
    check("excl_tail_grant", 32'(o_grant), 32'b0100);
    check("excl_tail_valid", 32'(o_valid), 32'b1000);

    // Output 0 stalled for five cycles, then granted the cycle ready returns.
    for (int c = 0; c < 5; c++) begin
      drive({4'b1000, 4'b0000, 4'b0000, 4'b0000}, 4'b1000, 4'b0111);
      check("t5_stall_sel0",  32'(o_sel[0]), 32'b1000);
      check("t5_stall_grant", 32'(o_grant),  32'b0000);
      check("t5_stall_valid", 32'(o_valid),  32'b0000);
    end
    drive({4'b1000, 4'b0000, 4'b0000, 4'b0000}, 4'b1000, 4'b1111);
    check("t5_ready_grant", 32'(o_grant), 32'b1000);
    check("t5_ready_valid", 32'(o_valid), 32'b1000);

    // Reset in the middle of a packet from input 3 on output 2.
    drive({4'b0000, 4'b0000, 4'b0000, 4'b0010}, 4'b0000, 4'b1111);
    check("t6_head_grant", 32'(o_grant), 32'b0001);
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_sel",   32'(o_sel),   32'd0);
    check("t6_rst_grant", 32'(o_grant), 32'd0);
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    @(negedge clk);
    i_req   = '0;
    reset_n = 1'b1;
    drive({4'b1000, 4'b1000, 4'b0010, 4'b0000}, 4'b1111, 4'b1111);
    check("t6_post_sel0",  32'(o_sel[0]), 32'b1000);
    check("t6_post_sel2",  32'(o_sel[2]), 32'b0010);
    check("t6_post_grant", 32'(o_grant),  32'b1010);
    check("t6_post_valid", 32'(o_valid),  32'b1010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_lib_switch_allocator_onehot
